// File: rtl/common_pkg.sv
// Shared bus types for the core's instruction and data buses, plus the
// responder state encoding and its default memory base address.
package common;

  // Bus address that maps onto word 0 of the responder's array.
  localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h8000_0000;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_t;

endpackage

// File: rtl/bus_responder_sram_1p.sv
// Single-port 64-bit-wide RAM with per-byte write enables and a registered
// read port. Each byte lane is its own array so every lane maps onto a plain
// block RAM with a simple write enable. Contents have no reset.
module sram_1p #(
  parameter int WORDS = 4096,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          re,
  input  logic [7:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      logic [7:0] mem [WORDS];
      logic [7:0] q_reg;

      // Byte-lane write and registered read; q_reg holds when re is low.
      always_ff @(posedge clk) begin
        if (we[gi]) begin
          mem[addr] <= wdata[8*gi +: 8];
        end
        if (re) begin
          q_reg <= mem[addr];
        end
      end

      assign rdata[8*gi +: 8] = q_reg;
    end
  endgenerate

endmodule

// File: rtl/bus_responder.sv
// Memory-side responder for the core's ibus and dbus. One transaction at a
// time: accept in IDLE (dbus has priority), count LATENCY wait cycles while
// the RAM read is issued, then present data_ok/data for one RESP cycle.
// dbus writes commit at the edge that ends RESP, so the response carries the
// word as it was before the write.
module bus_responder
  import common::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter logic [63:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          LATENCY   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp
);

  // MEM_WORDS must be a power of two and LATENCY must lie in 1..15 so it
  // fits the 4-bit wait counter.
  localparam int AW = $clog2(MEM_WORDS);

  resp_state_t   state_reg;
  logic [3:0]    cnt_reg;
  logic          src_d_reg;     // 1 = dbus transaction, 0 = ibus
  logic [AW-1:0] idx_reg;
  logic          half_reg;      // ibus: select upper 32 bits
  logic [7:0]    strobe_reg;
  logic [63:0]   wdata_reg;
  logic          iok_reg;
  logic          dok_reg;

  logic          accept_d;
  logic          accept_i;
  logic [63:0]   req_addr;
  logic [63:0]   addr_off;
  logic [AW-1:0] req_idx;
  logic          sram_re;
  logic [7:0]    sram_we;
  logic [63:0]   sram_q;
  logic          unused_bits;

  // Arbitration: only in IDLE and out of reset; dbus wins a tie.
  always_comb begin
    accept_d = reset && (state_reg == IDLE) && dreq.valid;
    accept_i = reset && (state_reg == IDLE) && !dreq.valid && ireq.valid;
    req_addr = accept_d ? dreq.addr : ireq.addr;
    addr_off = req_addr - BASE_ADDR;
    req_idx  = addr_off[AW+2:3];
  end

  // Out-of-range upper offset bits wrap silently; size is not used.
  assign unused_bits = ^{dreq.size, addr_off[63:AW+3], addr_off[2:0]};

  // Transaction FSM with registered data_ok strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= 4'd0;
      src_d_reg  <= 1'b0;
      idx_reg    <= '0;
      half_reg   <= 1'b0;
      strobe_reg <= 8'd0;
      wdata_reg  <= 64'd0;
      iok_reg    <= 1'b0;
      dok_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          iok_reg <= 1'b0;
          dok_reg <= 1'b0;
          if (accept_d || accept_i) begin
            src_d_reg  <= accept_d;
            idx_reg    <= req_idx;
            half_reg   <= req_addr[2];
            strobe_reg <= accept_d ? dreq.strobe : 8'd0;
            wdata_reg  <= dreq.data;
            cnt_reg    <= 4'(LATENCY);
            state_reg  <= WAIT;
          end
        end
        WAIT: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) begin
            state_reg <= RESP;
            dok_reg   <= src_d_reg;
            iok_reg   <= !src_d_reg;
          end
        end
        RESP: begin
          iok_reg   <= 1'b0;
          dok_reg   <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Read is reissued every WAIT cycle so the last one lands by RESP; the
  // write fires only in RESP, after the old word has been captured.
  always_comb begin
    sram_re = (state_reg == WAIT);
    sram_we = ((state_reg == RESP) && src_d_reg) ? strobe_reg : 8'd0;
  end

  sram_1p #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_sram (
    .clk   (clk),
    .re    (sram_re),
    .we    (sram_we),
    .addr  (idx_reg),
    .wdata (wdata_reg),
    .rdata (sram_q)
  );

  // Response buses: data fields are forced to zero outside data_ok.
  always_comb begin
    iresp         = '0;
    dresp         = '0;
    iresp.addr_ok = accept_i;
    iresp.data_ok = iok_reg;
    dresp.addr_ok = accept_d;
    dresp.data_ok = dok_reg;
    if (iok_reg) begin
      iresp.data = half_reg ? sram_q[63:32] : sram_q[31:0];
    end
    if (dok_reg) begin
      dresp.data = sram_q;
    end
  end

endmodule

// File: doc/bus_responder.md
# bus_responder

Memory-side responder for the core's instruction bus (ibus) and data bus (dbus). It accepts one request at a time, arbitrates between the two buses, and serves each request from an internal byte-writable single-port array after a fixed, configurable latency. It sits opposite the core and replaces the external memory model in standalone core simulation and on FPGA.

## Interface
- `MEM_WORDS`, default 4096: array depth in 64-bit words; must be a power of two.
- `BASE_ADDR`, default 64'h8000_0000: bus address that maps to word 0.
- `LATENCY`, default 2: wait cycles between accept and response; legal range 1..15.

- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset; 0 = in reset.
- `ireq` in `ibus_req_t`: instruction request; fields `valid`, `addr` (64 bits).
- `iresp` out `ibus_resp_t`: `addr_ok`, `data_ok`, `data` (32 bits).
- `dreq` in `dbus_req_t`: data request; fields `valid`, `addr`, `size`, `strobe` (8 bits), `data` (64 bits).
- `dresp` out `dbus_resp_t`: `addr_ok`, `data_ok`, `data` (64 bits).

## Operation
- The state machine has three states: IDLE, WAIT and RESP.
- **IDLE:** if `dreq.valid` is high, accept dbus. Otherwise, if `ireq.valid` is high, accept ibus. dbus always wins a simultaneous request; ibus stays pending and is not acknowledged.
- **Accept:**
  - Pulse the winner's `addr_ok` for exactly one cycle, in the accept cycle.
  - Latch the source, `addr`, `strobe` and `data`.
  - Load the wait counter with `LATENCY` and go to WAIT.
- **WAIT:** decrement the counter each cycle. On reaching 0, go to RESP.
- **RESP:**
  - Pulse the source's `data_ok` for one cycle.
  - Return to IDLE on the next edge.
  - A new request is never accepted in the RESP cycle.
- **Word index:** `(addr - BASE_ADDR) >> 3`, truncated modulo `MEM_WORDS`. Out-of-range addresses wrap silently. Alignment is not checked.
- **ibus read:** `iresp.data` = upper 32 bits of the word if `addr[2]` = 1, else the lower 32 bits.
- **dbus read** (`strobe` = 0): `dresp.data` = the full 64-bit word. Byte extraction and sign extension are the core's job.
- **dbus write** (`strobe` ≠ 0):
  - Byte lane i is written with `data[8i+7:8i]` where `strobe[i]` = 1.
  - The write commits at the RESP edge.
  - `dresp.data` = the old word, read before the write.
- Outside its `data_ok` cycle, each `data` field is held at 0.
- `valid` dropped before `addr_ok`: no transaction occurs. After `addr_ok`, request fields are ignored until `data_ok`.
- `size` is ignored; `strobe` alone defines the write.

## Timing
- All `iresp`/`dresp` fields are 0 while in reset and on reset release.
- The state is IDLE and the counter is 0 in reset.
- Accept in cycle T (`addr_ok` = 1) → `data_ok` = 1 in cycle T + `LATENCY` + 1.
- Peak throughput is one transaction per `LATENCY` + 2 cycles.
- `addr_ok` is combinational from `valid` in IDLE. `data_ok` and `data` are registered.
- Reset asserted mid-transaction:
  - The transaction is aborted and all outputs go to 0 immediately.
  - A pending write is dropped.
  - Array contents are preserved; reset never clears memory.
- `addr_ok` and `data_ok` are never high for both buses in the same cycle.

## Structure
- Add `resp_state_t` (IDLE/WAIT/RESP) and the default `BASE_ADDR` to the shared `common` package, alongside the existing bus typedefs.
- One sub-module, `sram_1p`:
  - Holds `MEM_WORDS` × 64-bit words.
  - Synchronous read, byte-enable write, single port.
  - Read data is issued in WAIT so that it is valid by RESP.
- The responder drives `sram_1p`'s address, write-enable and strobe from its latched request.

## Test plan
- **Reset:** hold `reset` = 0 with both `valid`s high → all `addr_ok`/`data_ok`/`data` = 0 throughout.
- **dbus write then read (`LATENCY` = 2):**
  - Write 64'h1122_3344_5566_7788 to 64'h8000_0010 with `strobe` = 8'hFF: `addr_ok` at T, `data_ok` at T+3.
  - Read the same address: `dresp.data` = 64'h1122_3344_5566_7788.
- **Partial write:** `strobe` = 8'h0F, data 64'hAAAA_AAAA_BBBB_BBBB over the word above → subsequent read = 64'h1122_3344_BBBB_BBBB.
- **ibus half select:**
  - Fetch 64'h8000_0010 → `iresp.data` = 32'h5566_7788.
  - Fetch 64'h8000_0014 → `iresp.data` = 32'h1122_3344.
- **Arbitration:** both `valid`s rise together → dbus `addr_ok` first. ibus `addr_ok` at the IDLE cycle after dbus `data_ok`. `iresp` is never asserted during the dbus transaction.
- **Reset mid-operation and wrap:**
  - Write 64'hFF to `BASE_ADDR` + 8·`MEM_WORDS` (wraps to word 0) → read of `BASE_ADDR` returns 64'hFF.
  - Assert reset during WAIT of a write to word 1 → outputs 0 at once, and a later read of word 1 returns its prior value.
